// File: rtl/ac_serial_acc_bank_if.sv
// rtl/ac_serial_acc_bank_if.sv - start/psum/result handshake bundle for the serial accumulator bank
interface ac_serial_acc_bank_if #(
    parameter int M  = 16,
    parameter int PA = 8,
    parameter int N  = 4
);
    localparam int W  = $clog2(M) + 1;
    localparam int OW = $clog2(M) + PA + 1;
    localparam int PW = $clog2(PA) + 1;

    logic            start;
    logic [PW-1:0]   prec;
    logic            signed_mode;
    logic            in_valid;
    logic            in_ready;
    logic [N*W-1:0]  psum;
    logic            out_valid;
    logic            out_ready;
    logic [N*OW-1:0] result;
    logic            busy;

    modport master (
        output start, prec, signed_mode, in_valid, psum, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  start, prec, signed_mode, in_valid, psum, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/ac_serial_acc_bank.sv
// rtl/ac_serial_acc_bank.sv - N-lane bit-serial shift-add accumulator, LSB-first psum beats
module ac_serial_acc_bank #(
    parameter int M  = 16,
    parameter int PA = 8,
    parameter int N  = 4
) (
    input logic                clk,
    input logic                rst,
    ac_serial_acc_bank_if.slave bus
);
    localparam int W  = $clog2(M) + 1;
    localparam int OW = $clog2(M) + PA + 1;
    localparam int PW = $clog2(PA) + 1;
    localparam int CW = W + 1 + PA;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          p_q, p_d;
    logic [PW-1:0]          cnt_q, cnt_d;
    logic                   sgn_q, sgn_d;
    logic [N-1:0][W:0]      h_q, h_d;
    logic [N-1:0][PA-1:0]   l_q, l_d;
    logic [N-1:0][OW-1:0]   res_q, res_d;

    logic [PW-1:0]          prec_eff;
    logic [PW-1:0]          shamt;
    logic                   last_beat;
    logic                   sub_beat;
    logic                   load;
    logic [N-1:0][W+1:0]    t;
    logic [N-1:0][W:0]      h_nx;
    logic [N-1:0][PA-1:0]   l_nx;
    logic [N-1:0][CW-1:0]   shifted;

    always_comb begin
        prec_eff = bus.prec;
        if (bus.prec == '0 || bus.prec > PW'(PA)) begin
            prec_eff = PW'(PA);
        end
    end

    assign last_beat = (cnt_q == p_q - PW'(1));
    assign sub_beat  = sgn_q && last_beat;
    assign shamt     = PW'(PA) - p_q;

    // High part carries the running sum; each beat retires one settled bit into L.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (sub_beat) begin
                t[i] = {h_q[i][W], h_q[i]} - {2'b00, bus.psum[i*W +: W]};
            end else begin
                t[i] = {h_q[i][W], h_q[i]} + {2'b00, bus.psum[i*W +: W]};
            end
            h_nx[i]    = t[i][W+1:1];
            l_nx[i]    = {t[i][0], l_q[i][PA-1:1]};
            shifted[i] = $signed({h_nx[i], l_nx[i]}) >>> shamt;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        h_d     = h_q;
        l_d     = l_q;
        res_d   = res_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load = 1'b1;
                end
            end
            ACC: begin
                if (bus.in_valid) begin
                    h_d   = h_nx;
                    l_d   = l_nx;
                    cnt_d = cnt_q + PW'(1);
                    if (last_beat) begin
                        state_d = DONE;
                        for (int i = 0; i < N; i++) begin
                            res_d[i] = shifted[i][OW-1:0];
                        end
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (bus.start) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            state_d = ACC;
            p_d     = prec_eff;
            sgn_d   = bus.signed_mode;
            cnt_d   = '0;
            h_d     = '0;
            l_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            h_q     <= '0;
            l_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            h_q     <= h_d;
            l_q     <= l_d;
            res_q   <= res_d;
        end
    end

    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = res_q;
endmodule

// File: tb/tb_ac_serial_acc_bank.sv
// tb/tb_ac_serial_acc_bank.sv - directed and randomized checks of ac_serial_acc_bank against an arithmetic model
module tb_ac_serial_acc_bank;
    localparam int M  = 16;
    localparam int PA = 8;
    localparam int N  = 4;
    localparam int W  = $clog2(M) + 1;
    localparam int OW = $clog2(M) + PA + 1;
    localparam int PW = $clog2(PA) + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ac_serial_acc_bank_if #(.M(M), .PA(PA), .N(N)) bus ();

    ac_serial_acc_bank #(.M(M), .PA(PA), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          total  = 0;
    int          passed = 0;
    int          ps [N][PA];
    int          cur_p;
    bit          cur_sgn;
    int          cyc;
    logic [N*OW-1:0] snap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int model(input int lane);
        int acc = 0;
        for (int k = 0; k < cur_p; k++) begin
            if (cur_sgn && k == cur_p - 1) acc -= ps[lane][k] * (1 << k);
            else                           acc += ps[lane][k] * (1 << k);
        end
        return acc;
    endfunction

    task automatic drive_beat(input int k);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(ps[i][k]);
        bus.psum = v;
    endtask

    task automatic rand_psums();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < PA; k++) ps[i][k] = int'($urandom_range(0, M));
    endtask

    task automatic do_start(input int pr, input bit sg);
        bus.start       = 1'b1;
        bus.prec        = PW'(pr);
        bus.signed_mode = sg;
        cur_p   = (pr == 0 || pr > PA) ? PA : pr;
        cur_sgn = sg;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic feed(input bit bubbles, output int cycles);
        int k = 0;
        bit ir_ok = 1'b1;
        bit vld;
        cycles = 0;
        while (k < cur_p && cycles < 200) begin
            vld = bubbles ? (cycles % 2 == 0) : 1'b1;
            bus.in_valid = vld;
            drive_beat(k < PA ? k : 0);
            if (bus.in_ready !== 1'b1) ir_ok = 1'b0;
            @(negedge clk);
            cycles++;
            if (vld) k++;
        end
        bus.in_valid = 1'b0;
        check("beats_accepted", 32'(k), 32'(cur_p));
        check("in_ready_during_acc", 32'(ir_ok), 32'd1);
    endtask

    task automatic check_result(input string tag);
        int e;
        logic [OW-1:0] ev;
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < N; i++) begin
            e  = model(i);
            ev = e[OW-1:0];
            check($sformatf("%s_lane%0d", tag, i), 32'(bus.result[i*OW +: OW]), 32'(ev));
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.prec = '0; bus.signed_mode = 1'b0;
        bus.in_valid = 1'b0; bus.psum = '0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_result", 32'(bus.result == '0), 32'd1);

        // 1: unsigned p=8, lane0 psum 16 each beat
        for (int i = 0; i < N; i++) for (int k = 0; k < PA; k++) ps[i][k] = (i == 0) ? 16 : 0;
        do_start(8, 1'b0);
        feed(1'b0, cyc);
        check("t1_latency", 32'(cyc + 1), 32'd9);
        check_result("t1");
        check("t1_lane0_const", 32'(bus.result[0 +: OW]), 32'd4080);
        @(negedge clk);
        check("t1_idle_after", 32'(bus.busy), 32'd0);

        // 2: signed p=4, lane1 beats 3,0,0,2
        rand_psums();
        ps[1][0] = 3; ps[1][1] = 0; ps[1][2] = 0; ps[1][3] = 2;
        do_start(4, 1'b1);
        feed(1'b0, cyc);
        check_result("t2");
        check("t2_lane1_const", 32'(bus.result[OW +: OW]), 32'(13'h1FF3));
        @(negedge clk);

        // 3: test 1 with bubbles
        for (int i = 0; i < N; i++) for (int k = 0; k < PA; k++) ps[i][k] = (i == 0) ? 16 : 0;
        do_start(8, 1'b0);
        feed(1'b1, cyc);
        check("t3_cycles", 32'(cyc), 32'd15);
        check_result("t3");
        @(negedge clk);

        // 4: stall in DONE, start ignored, then back-to-back op
        rand_psums();
        bus.out_ready = 1'b0;
        do_start(5, 1'b1);
        feed(1'b0, cyc);
        check_result("t4a");
        snap = bus.result;
        for (int c = 0; c < 5; c++) begin
            bus.start = (c % 2 == 0);
            @(negedge clk);
            check("t4_result_stable", 32'(bus.result == snap), 32'd1);
            check("t4_in_ready_low", 32'(bus.in_ready), 32'd0);
            check("t4_out_valid_held", 32'(bus.out_valid), 32'd1);
        end
        bus.start = 1'b0;
        rand_psums();
        bus.out_ready = 1'b1;
        do_start(3, 1'b0);
        check("t4_b2b_out_valid", 32'(bus.out_valid), 32'd0);
        feed(1'b0, cyc);
        check_result("t4b");
        @(negedge clk);

        // 5: reset after 3 beats, then a clean op
        rand_psums();
        do_start(8, 1'b0);
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            drive_beat(k);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        check("t5_rst_busy", 32'(bus.busy), 32'd0);
        check("t5_rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("t5_rst_result", 32'(bus.result == '0), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        rand_psums();
        do_start(6, 1'b1);
        feed(1'b0, cyc);
        check_result("t5");
        @(negedge clk);

        // 6: p=1 signed, then prec=0 clamp
        for (int i = 0; i < N; i++) ps[i][0] = 5;
        do_start(1, 1'b1);
        feed(1'b0, cyc);
        check_result("t6a");
        check("t6a_lane0_const", 32'(bus.result[0 +: OW]), 32'(13'h1FFB));
        @(negedge clk);
        for (int i = 0; i < N; i++) for (int k = 0; k < PA; k++) ps[i][k] = 1;
        do_start(0, 1'b0);
        feed(1'b0, cyc);
        check("t6b_latency", 32'(cyc + 1), 32'd9);
        check_result("t6b");
        check("t6b_lane3_const", 32'(bus.result[3*OW +: OW]), 32'd255);
        @(negedge clk);

        // randomized ops
        for (int r = 0; r < 8; r++) begin
            rand_psums();
            do_start(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            feed(1'($urandom_range(0, 1)), cyc);
            check_result($sformatf("rand%0d", r));
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
